// File: rtl/cdr_rate_estimator.sv
// cdr_rate_estimator
//   Measures the symbol period of the sliced bit stream during an alternating
//   1010... preamble. It averages 2^LOG2_NSYM symbol intervals and publishes
//   the mean period as a 10-bit integer divider plus a 22-bit fraction for the
//   CDR fractional clock generator.
//
// Ports
//   clk      in   fabric clock (only clock)
//   reset    in   synchronous, active-high
//   enable   in   estimation runs while high
//   data_in  in   asynchronous sliced bit stream
//   div      out  integer part of the symbol period, clk cycles
//   div_frac out  fractional part of the period x 2^22
//   new_data out  one-cycle strobe; div/div_frac change only in this cycle
//   locked   out  a valid estimate has been published since enable rose
//   err      out  one-cycle strobe on a rejected interval or timeout
//
// State table
//   IDLE    | enable low; outputs hold, locked cleared
//   ARM     | waiting for the reference edge
//   MEASURE | accumulating intervals against the first interval I0
//   PUBLISH | one cycle after the estimate is loaded; then re-arm
module cdr_rate_estimator #(
  parameter int LOG2_NSYM = 5,
  parameter int MIN_DIV   = 20,
  parameter int MAX_DIV   = 1023,
  parameter int TOL_SHIFT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        data_in,
  output logic [9:0]  div,
  output logic [21:0] div_frac,
  output logic        new_data,
  output logic        locked,
  output logic        err
);

  localparam int TW = 10 + LOG2_NSYM + 1;
  localparam int EW = LOG2_NSYM + 1;
  localparam logic [10:0]   ICNT_SAT = 11'(MAX_DIV + 1);
  localparam logic [10:0]   MIN_I    = 11'(MIN_DIV);
  localparam logic [EW-1:0] LAST_E   = EW'((1 << LOG2_NSYM) - 1);

  typedef enum logic [1:0] {IDLE, ARM, MEASURE, PUBLISH} state_t;

  state_t        state_q;
  logic          s1_q, s2_q, s3_q;
  logic [10:0]   icnt_q, icnt_d;
  logic [TW-1:0] tot_q;
  logic [EW-1:0] ecnt_q;
  logic [10:0]   i0_q;
  logic [9:0]    div_q;
  logic [21:0]   div_frac_q;
  logic          new_data_q, locked_q, err_q;

  logic          edge_det;
  logic [TW-1:0] tot_sum;
  logic [10:0]   dev;
  logic [10:0]   tol;
  logic          out_of_tol;
  logic [9:0]    div_d;
  logic [21:0]   div_frac_d;

  assign edge_det = s2_q ^ s3_q;

  // Synchronizer plus a third stage for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= data_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // Interval counter: value at an edge is the cycle count since the previous edge
  always_comb begin
    icnt_d = icnt_q;
    if (edge_det)
      icnt_d = 11'd1;
    else if (icnt_q != ICNT_SAT)
      icnt_d = icnt_q + 11'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) icnt_q <= '0;
    else       icnt_q <= icnt_d;
  end

  always_comb begin
    tot_sum    = tot_q + TW'(icnt_q);
    dev        = (icnt_q >= i0_q) ? (icnt_q - i0_q) : (i0_q - icnt_q);
    tol        = i0_q >> TOL_SHIFT;
    out_of_tol = (ecnt_q != '0) && (dev > tol);
    div_d      = tot_sum[LOG2_NSYM+9:LOG2_NSYM];
    // fraction bits left-justified into the 22-bit field
    div_frac_d = 22'(tot_sum[LOG2_NSYM-1:0]) << (22 - LOG2_NSYM);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      tot_q      <= '0;
      ecnt_q     <= '0;
      i0_q       <= '0;
      div_q      <= '0;
      div_frac_q <= '0;
      new_data_q <= 1'b0;
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      new_data_q <= 1'b0;
      err_q      <= 1'b0;
      if (!enable) begin
        state_q  <= IDLE;
        locked_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: state_q <= ARM;
          ARM: begin
            if (edge_det) begin
              tot_q   <= '0;
              ecnt_q  <= '0;
              state_q <= MEASURE;
            end
          end
          MEASURE: begin
            if (edge_det) begin
              if (icnt_q < MIN_I) begin
                err_q   <= 1'b1;
                state_q <= ARM;
              end else if (out_of_tol) begin
                // this edge becomes the new reference
                err_q  <= 1'b1;
                tot_q  <= '0;
                ecnt_q <= '0;
              end else begin
                if (ecnt_q == '0) i0_q <= icnt_q;
                tot_q  <= tot_sum;
                ecnt_q <= ecnt_q + 1'b1;
                if (ecnt_q == LAST_E) begin
                  if (tot_sum[TW-1]) begin
                    err_q   <= 1'b1;
                    state_q <= ARM;
                  end else begin
                    div_q      <= div_d;
                    div_frac_q <= div_frac_d;
                    new_data_q <= 1'b1;
                    locked_q   <= 1'b1;
                    state_q    <= PUBLISH;
                  end
                end
              end
            end else if (icnt_q == ICNT_SAT) begin
              err_q   <= 1'b1;
              state_q <= ARM;
            end
          end
          PUBLISH: state_q <= ARM;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign div      = div_q;
  assign div_frac = div_frac_q;
  assign new_data = new_data_q;
  assign locked   = locked_q;
  assign err      = err_q;

endmodule

// File: tb/tb_cdr_rate_estimator.sv
module tb_cdr_rate_estimator;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        data_in;
  logic [9:0]  div;
  logic [21:0] div_frac;
  logic        new_data;
  logic        locked;
  logic        err;

  cdr_rate_estimator dut (
    .clk(clk), .reset(reset), .enable(enable), .data_in(data_in),
    .div(div), .div_frac(div_frac), .new_data(new_data),
    .locked(locked), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  int obs_cyc[$];
  int obs_div[$];
  int obs_frac[$];
  int obs_err = 0;

  always @(negedge clk) begin
    if (new_data) begin
      obs_cyc.push_back(cyc);
      obs_div.push_back(int'(div));
      obs_frac.push_back(int'(div_frac));
    end
    if (err) obs_err++;
    if (new_data || err) begin
      n_cmp++;
      assert ((new_data & err) === 1'b0)
      else begin
        n_bad++;
        $error("FAIL excl observed new_data=%0b err=%0b expected not both", new_data, err);
      end
    end
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference model: works on the list of toggle times only
  int tog[$];
  int exp_cyc[$];
  int exp_div[$];
  int exp_frac[$];
  int exp_err;
  int s_pub, s_err;
  int last_div = 0, last_frac = 0;

  function automatic void model();
    bit arm = 1;
    int n = 0, sum = 0, i0 = 0, iv, d;
    exp_cyc.delete(); exp_div.delete(); exp_frac.delete();
    exp_err = 0;
    for (int i = 0; i < tog.size(); i++) begin
      if (i == 0 || arm) begin
        arm = 0; n = 0; sum = 0;
        continue;
      end
      iv = tog[i] - tog[i-1];
      if (iv > 1024) begin           // timed out, this toggle becomes the reference
        exp_err++; n = 0; sum = 0;
        continue;
      end
      if (iv < 20) begin
        exp_err++; arm = 1;
        continue;
      end
      d = (iv > i0) ? iv - i0 : i0 - iv;
      if (n > 0 && d > i0 / 4) begin
        exp_err++; n = 0; sum = 0;
        continue;
      end
      if (n == 0) i0 = iv;
      sum += iv;
      n++;
      if (n == 32) begin
        if (sum >= 32768) exp_err++;
        else begin
          exp_cyc.push_back(tog[i] + 3);
          exp_div.push_back(sum / 32);
          exp_frac.push_back((sum % 32) * 131072);
        end
        arm = 1;
      end
    end
  endfunction

  task automatic toggle_after(input int gap);
    repeat (gap) @(posedge clk);
    #1 data_in = ~data_in;
    tog.push_back(cyc);
  endtask

  task automatic scn_begin();
    tog.delete();
    s_pub = obs_cyc.size();
    s_err = obs_err;
    enable = 1'b1;
    toggle_after(3);
  endtask

  task automatic run_const(input int iv, input int cnt);
    for (int k = 0; k < cnt; k++) toggle_after(iv);
  endtask

  task automatic scn_check(input string tag);
    repeat (30) @(posedge clk);
    @(negedge clk);
    model();
    chk({tag, ".npub"}, obs_cyc.size() - s_pub, exp_cyc.size());
    for (int k = 0; k < exp_cyc.size(); k++) begin
      if (s_pub + k < obs_cyc.size()) begin
        chk({tag, ".cyc"},  obs_cyc[s_pub+k],  exp_cyc[k]);
        chk({tag, ".div"},  obs_div[s_pub+k],  exp_div[k]);
        chk({tag, ".frac"}, obs_frac[s_pub+k], exp_frac[k]);
      end
    end
    chk({tag, ".nerr"}, obs_err - s_err, exp_err);
    chk({tag, ".locked"}, locked, (exp_cyc.size() > 0) ? 1 : 0);
    if (exp_cyc.size() > 0) begin
      last_div  = exp_div[exp_div.size()-1];
      last_frac = exp_frac[exp_frac.size()-1];
    end
  endtask

  task automatic scn_disable(input string tag);
    int p;
    p = obs_cyc.size();
    enable = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk({tag, ".dis_locked"}, locked, 0);
    chk({tag, ".dis_div"}, div, last_div);
    chk({tag, ".dis_frac"}, div_frac, last_frac);
    chk({tag, ".dis_nopub"}, obs_cyc.size(), p);
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base, r, iv, p;
    reset = 1'b1; enable = 1'b0; data_in = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.div", div, 0);
    chk("rst.frac", div_frac, 0);
    chk("rst.locked", locked, 0);
    chk("rst.new_data", new_data, 0);
    chk("rst.err", err, 0);
    reset = 1'b0;
    repeat (2) @(posedge clk);

    // steady 100-cycle symbols
    scn_begin(); run_const(100, 40); scn_check("s100");
    chk("s100.div_lit", div, 100);
    scn_disable("s100");

    // alternating 100/101
    scn_begin();
    for (int k = 0; k < 35; k++) begin toggle_after(100); toggle_after(101); end
    scn_check("alt");
    chk("alt.frac_lit", div_frac, 22'h200000);
    scn_disable("alt");

    // outlier restarts measurement; 124 is still within tolerance
    scn_begin();
    run_const(100, 5); toggle_after(130);
    toggle_after(100); toggle_after(124); run_const(100, 30);
    scn_check("outl");
    scn_disable("outl");

    // too-short intervals
    scn_begin(); run_const(15, 10); scn_check("short");
    scn_disable("short");

    // stuck input during MEASURE
    scn_begin(); run_const(100, 10); toggle_after(1100); run_const(100, 3);
    scn_check("stuck");
    chk("stuck.div_hold", div, last_div);
    scn_disable("stuck");

    // enable drop mid-measurement
    scn_begin(); run_const(100, 52); scn_check("edrop");
    scn_disable("edrop");

    // reset mid-measurement
    scn_begin(); run_const(90, 52); scn_check("rmid");
    p = obs_cyc.size();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rmid.div", div, 0);
    chk("rmid.frac", div_frac, 0);
    chk("rmid.locked", locked, 0);
    chk("rmid.nopub", obs_cyc.size(), p);
    last_div = 0; last_frac = 0;
    scn_disable("rmid");

    // randomized preambles with glitches and outliers
    for (int rep = 0; rep < 2; rep++) begin
      base = int'($urandom_range(20, 200));
      scn_begin();
      for (int k = 0; k < 110; k++) begin
        r = int'($urandom_range(0, 99));
        if (r < 6)       iv = int'($urandom_range(3, 19));
        else if (r < 10) iv = base + base / 2 + int'($urandom_range(0, 20));
        else             iv = base - base / 4 + int'($urandom_range(0, base / 2));
        if (iv < 3) iv = 3;
        toggle_after(iv);
      end
      scn_check("rand");
      scn_disable("rand");
    end

    // re-enable after all of the above still gives a correct estimate
    scn_begin(); run_const(150, 33); scn_check("re");
    chk("re.div_lit", div, 150);
    scn_disable("re");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
